// File: rtl/bcd_stream_pkg.sv
// Shared state encoding and ASCII constants for the BCD-to-ASCII text streamer.
package bcd_stream_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SKIP = 3'd1,
    ST_SEND = 3'd2,
    ST_CR   = 3'd3,
    ST_LF   = 3'd4
  } state_t;

  localparam logic [BYTE_W-1:0] ASCII_ZERO = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_CR   = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF   = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_BAD  = 8'h3F;

endpackage

// File: rtl/bcd_digit_ascii.sv
// Combinational BCD digit to ASCII character; non-decimal nibbles map to '?'.
module bcd_digit_ascii
  import bcd_stream_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [BYTE_W-1:0]  ascii_c
);

  always_comb begin
    ascii_c = ASCII_BAD;
    if (digit <= DIGIT_W'(9)) ascii_c = ASCII_ZERO + BYTE_W'(digit);
  end

endmodule

// File: rtl/bcd_ascii_streamer.sv
// Streams a captured packed BCD word as ASCII decimal text (MS digit first) followed by CR LF.
// Optional leading-zero suppression is enabled by defining BCD_LEADING_ZERO_SUPPRESS_EN.
module bcd_ascii_streamer
  import bcd_stream_pkg::*;
#(
  parameter int unsigned DECIMAL_LENGTH = 39
)(
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [DECIMAL_LENGTH*DIGIT_W-1:0]   BCD_data,
  input  logic                                BCD_ready,
  output logic [BYTE_W-1:0]                   tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic                                busy,
  output logic                                overrun
);

  localparam int unsigned IDX_W  = $clog2(DECIMAL_LENGTH);
  localparam int unsigned DATA_W = DECIMAL_LENGTH * DIGIT_W;
  localparam int unsigned SEL_W  = $clog2(DATA_W);

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic [DATA_W-1:0]   shadow;
  logic                ready_q;
  logic                rise;
  logic                accept;
  logic [SEL_W-1:0]    sel;
  logic [DIGIT_W-1:0]  digit;
  logic [BYTE_W-1:0]   digit_ascii;

  assign rise   = BCD_ready & ~ready_q;
  assign accept = tx_valid & tx_ready;
  assign sel    = SEL_W'(idx) * SEL_W'(DIGIT_W);
  assign digit  = shadow[sel +: DIGIT_W];

  bcd_digit_ascii u_ascii (
    .digit   (digit),
    .ascii_c (digit_ascii)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Digit index, captured word, edge detector and overrun pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx     <= '0;
      shadow  <= '0;
      ready_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      idx     <= idx_next;
      ready_q <= BCD_ready;
      overrun <= rise && (state != ST_IDLE);
      if (state == ST_IDLE && rise) shadow <= BCD_data;
    end
  end

  // Next state and next digit index
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_SKIP;
          idx_next   = IDX_W'(DECIMAL_LENGTH - 1);
        end
      end
      ST_SKIP: begin
`ifdef BCD_LEADING_ZERO_SUPPRESS_EN
        // digit 0 is never skipped so an all-zero word still prints "0"
        if (digit == '0 && idx != '0) idx_next = idx - IDX_W'(1);
        else                          state_next = ST_SEND;
`else
        state_next = ST_SEND;
`endif
      end
      ST_SEND: begin
        if (accept) begin
          if (idx == '0) state_next = ST_CR;
          else           idx_next   = idx - IDX_W'(1);
        end
      end
      ST_CR:   if (accept) state_next = ST_LF;
      ST_LF:   if (accept) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stream outputs decoded from registered state
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = digit_ascii;
      end
      ST_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
      end
      ST_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Self-checking bench for bcd_ascii_streamer; expected frames come from a digit-array text model.
// Honours BCD_LEADING_ZERO_SUPPRESS_EN the same way as the design build.
module tb_bcd_ascii_streamer;

  localparam int unsigned DL = 39;
  localparam int unsigned W  = DL * 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [W-1:0]  BCD_data;
  logic          BCD_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          overrun;

  int unsigned total  = 0;
  int unsigned passes = 0;
  int          d[DL];
  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  int          exp_first;

  always #5 CLK = ~CLK;

  bcd_ascii_streamer #(.DECIMAL_LENGTH(DL)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BCD_data  (BCD_data),
    .BCD_ready (BCD_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Text model: decimal digits as characters, optional leading-zero drop, then CR LF
  function automatic void build_expected();
    int start;
    exp_q.delete();
    start = DL - 1;
`ifdef BCD_LEADING_ZERO_SUPPRESS_EN
    while (start > 0 && d[start] == 0) start--;
`endif
    exp_first = 2 + (DL - 1 - start);
    for (int i = start; i >= 0; i--)
      exp_q.push_back(d[i] <= 9 ? byte'(8'h30 + d[i]) : byte'(8'h3F));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic set_value(input longint unsigned v);
    for (int i = 0; i < DL; i++) begin
      d[i] = int'(v % 10);
      v = v / 10;
    end
  endtask

  task automatic set_random();
    int nz;
    nz = $urandom_range(0, DL - 1);
    for (int i = 0; i < DL; i++) d[i] = (i < DL - nz) ? int'($urandom_range(0, 9)) : 0;
    d[DL - 1 - nz] = $urandom_range(1, 9);
    if ($urandom_range(0, 3) == 0) d[$urandom_range(0, DL - 1 - nz)] = $urandom_range(10, 15);
  endtask

  task automatic drive_word();
    for (int i = 0; i < DL; i++) BCD_data[4*i +: 4] = 4'(d[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  // Caller has already made the rise visible; mode 0 ready, 1 toggle, 2 random
  task automatic run_frame(input int mode, input int poke_off, input bit hold);
    int  edges;
    int  poke;
    bit  prev_stall;
    bit  first_seen;
    bit  done;
    byte unsigned prev_data;
    edges = 0; prev_stall = 0; first_seen = 0; done = 0; prev_data = 0;
    got_q.delete();
    build_expected();
    poke = (poke_off > 0) ? exp_first + poke_off : 0;
    while (!done && edges < 400) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      if (!hold && edges == 1) BCD_ready = 1'b0;
      if (prev_stall) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, prev_data);
      end
      if (tx_valid && !first_seen) begin
        first_seen = 1;
        check("first_valid_cycle", edges, exp_first);
      end
      if (poke > 0) begin
        if (edges == poke) begin
          BCD_ready = 1'b1;
          BCD_data  = ~BCD_data;
        end else if (edges == poke + 1) begin
          check("overrun_pulse", overrun, 1);
          BCD_ready = 1'b0;
        end else if (edges == poke + 2) begin
          check("overrun_end", overrun, 0);
        end
      end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = edges[0];
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (tx_data == 8'h0A) done = 1;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
    check("frame_done", done, 1);
    if (!hold) BCD_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("busy_after_lf", busy, 0);
    check("valid_after_lf", tx_valid, 0);
    check("frame_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
  endtask

  task automatic start_frame();
    drive_word();
    BCD_ready = 1'b1;
  endtask

  initial begin
    bit seen;
    RST = 1'b1; BCD_ready = 1'b0; tx_ready = 1'b0; BCD_data = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", tx_data, 0);
    RST = 1'b0;
    idle(2);

    set_value(54);         start_frame(); run_frame(0, 0, 0); idle(2);
    set_value(0);          start_frame(); run_frame(0, 0, 0); idle(2);
    set_value(123);        start_frame(); run_frame(1, 0, 0); idle(2);
    set_value(987654321);  start_frame(); run_frame(0, 1, 0); idle(2);
    set_value(12); d[1] = 10; start_frame(); run_frame(1, 0, 0); idle(2);

    // reset in the middle of a frame
    set_value(64'd9876543210); start_frame();
    seen = 0;
    tx_ready = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      BCD_ready = 1'b0;
      if (tx_valid) seen = 1;
    end
    check("reached_send", seen, 1);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("midrst_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", tx_data, 0);
    RST = 1'b0;
    idle(3);
    check("no_resume_busy", busy, 0);

    // level held through reset gives exactly one capture
    RST = 1'b1; set_value(42); start_frame();
    idle(3);
    check("held_rst_busy", busy, 0);
    RST = 1'b0;
    run_frame(0, 0, 1);
    idle(3);
    check("held_no_recapture", busy, 0);
    BCD_ready = 1'b0;
    idle(2);

    for (int f = 0; f < 10; f++) begin
      set_random();
      start_frame();
      run_frame(2, int'($urandom_range(0, 3)), 0);
      idle(2);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
